// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Word/address geometry matches the fetch side (32-bit instrs, 64-bit PC).
package imem_loader_pkg;

  localparam int INSTR_W        = 32;
  localparam int ADDR_W         = 64;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects stream bytes into a little-endian instruction word.
// word_o already includes the byte being loaded this cycle, so the
// loader can register the complete word on the 4th-byte edge.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               load_byte_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_full_o
);

  logic [BYTES_PER_WORD-1:0][7:0] lanes_q, lanes_d;
  logic [BIDX_W-1:0]              idx_q, idx_d;

  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clear_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (load_byte_i) begin
      lanes_d[idx_q] = byte_i;
      idx_d          = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o      = lanes_d;
  assign word_full_o = load_byte_i && !clear_i &&
                       (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: 16-bit word-count header, then little-endian
// words written one per WRITE cycle; keeps the CPU held until the image lands.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_hold,
  output logic [CNT_W-1:0]   word_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d, n_hdr;
  logic [CNT_W-1:0]   wc_q, wc_d, wc_inc;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;

  logic               xfer, begin_load, load_byte, asm_clear, word_full;
  logic [INSTR_W-1:0] asm_word;

  assign xfer       = byte_valid && byte_ready;
  assign begin_load = start && (state_q inside {IDLE, DONE, ERR});
  assign load_byte  = (state_q == DATA) && xfer;
  assign asm_clear  = begin_load || (state_q == WRITE);
  assign n_hdr      = CNT_W'({byte_data, n_q[7:0]});
  assign wc_inc     = wc_q + 1'b1;

  imem_word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (asm_clear),
    .load_byte_i (load_byte),
    .byte_i      (byte_data),
    .word_o      (asm_word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) state_d = HDR0;
      HDR0:            if (xfer) state_d = HDR1;
      HDR1: begin
        if (xfer) begin
          if (n_hdr == '0)                 state_d = DONE;
          else if (n_hdr > CNT_W'(DEPTH))  state_d = ERR;
          else                             state_d = DATA;
        end
      end
      DATA:            if (word_full) state_d = WRITE;
      WRITE:           state_d = (wc_inc == n_q) ? DONE : DATA;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    unique case (state_q)
      HDR0, HDR1, DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE:   busy = 1'b1;
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  // Write port is registered: the word is captured on its 4th-byte edge and
  // presented during the following (WRITE) cycle; addr/data hold afterwards.
  always_comb begin
    n_d       = n_q;
    wc_d      = wc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (begin_load) begin
      n_d  = '0;
      wc_d = '0;
    end
    if ((state_q == HDR0) && xfer) n_d[7:0] = byte_data;
    if ((state_q == HDR1) && xfer) n_d      = n_hdr;
    if (word_full) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ADDR_W'({wc_q, {BIDX_W{1'b0}}});
      wr_data_d = asm_word;
    end
    if (state_q == WRITE) wc_d = wc_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q       <= '0;
      wc_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      n_q       <= n_d;
      wc_q      <= wc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued by the
// stimulus and popped by a negedge monitor whenever wr_en is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, wr_en, busy, done, error, cpu_hold;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] word_count;

  imem_loader #(.DEPTH(13), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  gap = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  wr_t e;
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", {32'h0, wr_data}, {32'h0, e.data});
        chk("ready_in_write", {63'h0, byte_ready}, 64'h0);
      end
    end
  end

  // Called and returning at a negedge; the byte moves on the posedge after
  // the cycle where ready is seen high.
  task automatic send(input logic [7:0] b);
    int t;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready_seen", {63'h0, (t < 100)}, 64'h1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [63:0] addr);
    wr_t x;
    x.addr = addr;
    x.data = w;
    exp_q.push_back(x);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic do_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    byte_valid = 1'b0;
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, {63'h0, done}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_flags", {58'h0, byte_ready, wr_en, busy, done, error, cpu_hold}, 64'h1);
    chk("reset_addr", wr_addr, 64'h0);
    chk("reset_data", {32'h0, wr_data}, 64'h0);
    chk("reset_wc", {48'h0, word_count}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", {62'h0, cpu_hold, done}, 64'h2);

    // Nominal N=2
    do_start();
    chk("hdr0_ready", {63'h0, byte_ready}, 64'h1);
    send(8'h02); send(8'h00);
    send_word(32'h00500013, 64'd0);
    send_word(32'h00100093, 64'd4);
    wait_done("nominal_done");
    chk("nominal_flags", {61'h0, cpu_hold, busy, error}, 64'h0);
    chk("nominal_wc", {48'h0, word_count}, 64'd2);
    chk("done_ready", {63'h0, byte_ready}, 64'h0);

    // Reload from DONE with a start pulse mid-DATA that must be ignored
    do_start();
    chk("reload_cpu_hold", {62'h0, cpu_hold, done}, 64'h2);
    send(8'h01); send(8'h00);
    begin
      wr_t x;
      x.addr = 64'd0;
      x.data = 32'hDEADBEEF;
      exp_q.push_back(x);
    end
    send(8'hEF); send(8'hBE);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_start_busy", {63'h0, busy}, 64'h1);
    send(8'hAD); send(8'hDE);
    wait_done("reload_done");
    chk("reload_wc", {48'h0, word_count}, 64'd1);

    // Same N=2 image with valid toggling every cycle
    gap = 1'b1;
    do_start();
    send(8'h02); send(8'h00);
    send_word(32'h00500013, 64'd0);
    send_word(32'h00100093, 64'd4);
    gap = 1'b0;
    wait_done("gap_done");
    chk("gap_wc", {48'h0, word_count}, 64'd2);

    // N=0: done right after the second header transfer
    do_start();
    send(8'h00); send(8'h00);
    byte_valid = 1'b0;
    chk("n0_done", {63'h0, done}, 64'h1);
    chk("n0_wc", {48'h0, word_count}, 64'd0);

    // N=DEPTH: last write lands at byte address 48
    do_start();
    send(8'h0D); send(8'h00);
    for (int i = 0; i < 13; i++)
      send_word({8'h0A, 8'h0B, 8'h0C, 8'(i)}, 64'(i * 4));
    wait_done("depth_done");
    chk("depth_wc", {48'h0, word_count}, 64'd13);
    chk("depth_last_addr", wr_addr, 64'd48);

    // Overflow N=14
    do_start();
    send(8'h0E); send(8'h00);
    byte_valid = 1'b0;
    chk("ovf_flags", {60'h0, error, cpu_hold, done, busy}, 64'hC);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_ready", {63'h0, byte_ready}, 64'h0);
      @(negedge clk);
    end
    do_start();
    chk("ovf_restart_err", {62'h0, error, cpu_hold}, 64'h1);
    send(8'h01); send(8'h00);
    send_word(32'h11223344, 64'd0);
    wait_done("ovf_recover_done");

    // Reset after two bytes of word 1 in an N=3 load
    do_start();
    send(8'h03); send(8'h00);
    send_word(32'hCAFEF00D, 64'd0);
    send(8'h77); send(8'h88);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_flags", {58'h0, byte_ready, wr_en, busy, done, error, cpu_hold}, 64'h1);
    chk("mid_reset_data", {32'h0, wr_data}, 64'h0);
    chk("mid_reset_addr", wr_addr, 64'h0);
    chk("mid_reset_wc", {48'h0, word_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start();
    send(8'h01); send(8'h00);
    send_word(32'hD4C3B2A1, 64'd0);
    wait_done("post_reset_done");
    chk("post_reset_wc", {48'h0, word_count}, 64'd1);

    repeat (5) @(negedge clk);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and issues one write per word into the instruction store at byte address word_index*4, matching the PC>>2 word indexing on the fetch side.
- Holds the CPU in reset until the program image is complete.
- Sits between the boot/debug byte source and the instruction memory write port.

Parameters:
- DEPTH, 13, number of 32-bit words in the instruction store; image lengths above DEPTH are rejected.
- CNT_W, 16, width of the header word count and of word_count.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a load (honoured in IDLE, DONE, ERR)
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte_data this cycle
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  64  byte address of the word being written (word_index<<2)
- wr_data  out  32  assembled instruction word
- busy  out  1  load in progress (HDR0..WRITE)
- done  out  1  image fully written; held until next start or reset
- error  out  1  header count > DEPTH; held until next start or reset
- cpu_hold  out  1  CPU reset request; 1 from reset until done
- word_count  out  CNT_W  words written so far in the current load

Behaviour:
- Transfer: a byte moves only on a cycle with byte_valid && byte_ready. byte_ready is combinational from state only (1 in HDR0, HDR1, DATA; 0 elsewhere). It never depends on byte_valid.
- Stream format: 2-byte header N (low byte first), then 4*N bytes. Each word is little-endian: first byte goes to wr_data[7:0], fourth byte to wr_data[31:24].
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1, word_count=0. The state is IDLE.
- Reset mid-load aborts with no further writes. Words already written stay in memory.
- FSM states and transitions:
  - IDLE: waits for start, then goes to HDR0. Clears word_count, byte_idx, done and error; sets cpu_hold=1.
  - HDR0: on a transfer, latches N[7:0] and goes to HDR1.
  - HDR1: on a transfer, latches N[15:8].
    - If N==0, goes to DONE.
    - If N>DEPTH, goes to ERR.
    - Otherwise goes to DATA.
  - DATA: each transfer shifts the byte into lane byte_idx (0..3) and increments byte_idx. On the 4th byte, goes to WRITE.
  - WRITE: exactly one cycle with wr_en=1, wr_addr={word_count,2'b00} zero-extended to 64 bits, wr_data=assembled word. byte_ready=0.
    - Next cycle: word_count increments and byte_idx resets to 0.
    - If word_count+1==N, goes to DONE; otherwise goes back to DATA.
  - DONE: done=1, cpu_hold=0, busy=0. Extra stream bytes are not accepted (byte_ready=0).
  - ERR: error=1, cpu_hold=1, no writes, byte_ready=0.
- start pulses are ignored in HDR0..WRITE. In DONE or ERR, start behaves as from IDLE: it goes straight to HDR0 with the same clearing (cpu_hold returns to 1).
- Latency:
  - A 4th-byte transfer at edge k gives wr_en high during cycle k+1.
  - A full load takes at least 2 + 5N cycles after start.
- wr_en, wr_addr and wr_data are registered outputs. wr_addr/wr_data hold their last values when wr_en=0.
- Byte stalls (byte_valid=0) in any receiving state leave all state unchanged, with no timeout.
- word_count never exceeds DEPTH.
- wr_addr is never at or above DEPTH*4.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR)
  - INSTR_W=32
  - ADDR_W=64 (matches PC width)
  - BYTES_PER_WORD=4
- Natural sub-module: imem_word_assembler (byte_idx counter plus 4-lane shift register, with clear and load_byte inputs, outputs word and word_full). The FSM stays in imem_loader.

Test Plan:
- Nominal load: start, N=2 (bytes 02 00), then 13 00 50 00 / 93 00 10 00 with byte_valid held high. Required response:
  - wr_en pulses at addr 0 with data 0x00500013, then at addr 4 with data 0x00100093.
  - done=1, cpu_hold=0, word_count=2.
- Backpressure and gaps: same image with byte_valid toggling 1/0 every cycle. Required response:
  - identical writes
  - byte_ready=0 during each WRITE cycle
  - no byte lost or duplicated
- Boundaries:
  - N=0 (00 00) gives done=1 two transfers after start, with no wr_en.
  - N=13 (DEPTH) gives the last write at addr 48, then done.
- Overflow: N=14 (0E 00) gives error=1, cpu_hold=1, no wr_en, and byte_ready=0 for subsequent bytes. A new start followed by a valid N=1 image then succeeds.
- Reset mid-operation: reset asserted after 2 data bytes of word 1 (N=3). Required response:
  - all outputs return to reset values, with no wr_en from reset onward.
  - A following full N=1 load writes addr 0 correctly (no stale lanes).
- Reload from DONE: after a completed N=2 load, start, then N=1 image 0xDEADBEEF (EF BE AD DE). Required response:
  - cpu_hold rises to 1 on the cycle after start.
  - Single write at addr 0 with 0xDEADBEEF, then done=1 again.
  - A start pulse issued mid-DATA is ignored.
